// File: rtl/pipeline_hazard_sequencer.sv
// Control-path pipeline registers for the 5-stage core: load-use stall,
// branch flush, EX operand forwarding selects and event counters.
module pipeline_hazard_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [31:0]      id_inst,
  input  logic [2:0]       id_exCtrl,
  input  logic [2:0]       id_memCtrl,
  input  logic [1:0]       id_wbCtrl,
  input  logic             mem_zero,
  output logic [2:0]       ex_ctrl,
  output logic [2:0]       mem_ctrl,
  output logic [1:0]       wb_ctrl,
  output logic [4:0]       mem_rd,
  output logic [4:0]       wb_rd,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             pc_src,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       valid;
    logic [2:0] ex;
    logic [2:0] mem;
    logic [1:0] wb;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] mem;
    logic [1:0] wb;
    logic [4:0] rd;
    logic       zero;
  } ex_mem_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] wb;
    logic [4:0] rd;
  } mem_wb_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUIP = 7'b0010111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  id_ex_t  idex_q, idex_d, id_b;
  ex_mem_t exmem_q, exmem_d, exm_adv;
  mem_wb_t memwb_q, memwb_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [6:0] opc;
  logic [4:0] rs1, rs2, rd;
  logic       use_rs1, use_rs2;
  logic       load_use, taken;
  logic       do_flush, do_stall;
  logic       exm_wr, mwb_wr;
  logic       unused_bits;

  assign opc = id_inst[6:0];
  assign rd  = id_inst[11:7];
  assign rs1 = id_inst[19:15];
  assign rs2 = id_inst[24:20];

  assign unused_bits = ^{id_inst[31:25], id_inst[14:12]};

  assign use_rs2 = (opc == OP_R) || (opc == OP_S) ||
                   (opc == OP_B);
  assign use_rs1 = !((opc == OP_LUI) || (opc == OP_AUIP) ||
                     (opc == OP_JAL));

  assign load_use = id_valid && idex_q.valid &&
                    idex_q.mem[2] && (idex_q.rd != 5'd0) &&
                    ((use_rs1 && (idex_q.rd == rs1)) ||
                     (use_rs2 && (idex_q.rd == rs2)));

  assign taken = exmem_q.valid && exmem_q.mem[0] &&
                 exmem_q.zero;

  // A taken branch squashes the stalled consumer, so it wins.
  assign do_flush = taken;
  assign do_stall = load_use && !taken;

  always_comb begin
    id_b = '0;
    if (id_valid) begin
      id_b.valid = 1'b1;
      id_b.ex    = id_exCtrl;
      id_b.mem   = id_memCtrl;
      id_b.wb    = id_wbCtrl;
      id_b.rs1   = rs1;
      id_b.rs2   = rs2;
      id_b.rd    = rd;
    end
  end

  always_comb begin
    exm_adv       = '0;
    exm_adv.valid = idex_q.valid;
    exm_adv.mem   = idex_q.mem;
    exm_adv.wb    = idex_q.wb;
    exm_adv.rd    = idex_q.rd;
    exm_adv.zero  = mem_zero;
  end

  always_comb begin
    idex_d        = id_b;
    exmem_d       = exm_adv;
    memwb_d       = '0;
    memwb_d.valid = exmem_q.valid;
    memwb_d.wb    = exmem_q.wb;
    memwb_d.rd    = exmem_q.rd;
    unique case (1'b1)
      do_flush: begin
        idex_d  = '0;
        exmem_d = '0;
      end
      do_stall: begin
        idex_d  = '0;
      end
      default: begin
        idex_d  = id_b;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (do_stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (do_flush && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q      <= '0;
      exmem_q     <= '0;
      memwb_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      idex_q      <= idex_d;
      exmem_q     <= exmem_d;
      memwb_q     <= memwb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign exm_wr = exmem_q.valid && exmem_q.wb[0] &&
                  (exmem_q.rd != 5'd0);
  assign mwb_wr = memwb_q.valid && memwb_q.wb[0] &&
                  (memwb_q.rd != 5'd0);

  // The younger producer (EX/MEM) holds the newest value.
  always_comb begin
    fwd_a = 2'b00;
    if (exm_wr && (exmem_q.rd == idex_q.rs1))
      fwd_a = 2'b10;
    else if (mwb_wr && (memwb_q.rd == idex_q.rs1))
      fwd_a = 2'b01;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (exm_wr && (exmem_q.rd == idex_q.rs2))
      fwd_b = 2'b10;
    else if (mwb_wr && (memwb_q.rd == idex_q.rs2))
      fwd_b = 2'b01;
  end

  assign pc_src     = do_flush;
  assign ifid_flush = do_flush;
  assign pc_write   = !do_stall;
  assign ifid_write = !do_stall;

  assign ex_ctrl   = idex_q.ex;
  assign mem_ctrl  = exmem_q.mem;
  assign wb_ctrl   = memwb_q.wb;
  assign mem_rd    = exmem_q.rd;
  assign wb_rd     = memwb_q.rd;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
